// File: rtl/mrmini_fetch_server.sv
// mrmini_fetch_server: instruction-side responder for the mini control unit.
// It owns the program counter and a small program store. A T1 edge latches
// MEM[PC] into I, PCE advances the PC, and JMP loads it. The program image is
// preloaded through the LD_* write port. All outputs come straight from
// registers, so no input reaches an output combinationally.
//
// Ports:
//   CLK, RST         clock (rising edge), asynchronous active-high reset
//   T1..T4           control-unit timing states; T1 triggers a fetch, and all
//                    four feed the protocol check
//   PCE, JMP, JADDR  PC increment enable, PC load strobe, PC load value
//   LD_EN/ADDR/DATA  program store write port
//   I                instruction register
//   PC               current program counter
//   FCNT             completed fetch count, saturating
//   ERR              sticky flag: two or more timing states were seen together
module mrmini_fetch_server #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 16,
  parameter int unsigned CW = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          T1,
  input  logic          T2,
  input  logic          T3,
  input  logic          T4,
  input  logic          PCE,
  input  logic          JMP,
  input  logic [AW-1:0] JADDR,
  input  logic          LD_EN,
  input  logic [AW-1:0] LD_ADDR,
  input  logic [DW-1:0] LD_DATA,
  output logic [DW-1:0] I,
  output logic [AW-1:0] PC,
  output logic [CW-1:0] FCNT,
  output logic          ERR
);

  localparam int unsigned Depth = 2 ** AW;

  logic [DW-1:0] mem_q [Depth];

  logic [DW-1:0] instr_q, instr_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [CW-1:0] fcnt_q, fcnt_d;
  logic          err_q, err_d;
  logic          multi_state;

  // The store is never reset. The fetch reads mem_q in the same edge as a
  // write, so a same-address write with T1 returns the old word.
  always_ff @(posedge CLK) begin
    if (LD_EN) begin
      mem_q[LD_ADDR] <= LD_DATA;
    end
  end

  // True when any pair of timing states is active together.
  assign multi_state = (T1 & T2) | (T1 & T3) | (T1 & T4) |
                       (T2 & T3) | (T2 & T4) | (T3 & T4);

  always_comb begin
    instr_d = instr_q;
    if (T1) begin
      instr_d = mem_q[pc_q];
    end

    // JMP takes priority over PCE. PC wraps naturally at AW bits.
    pc_d = pc_q;
    if (JMP) begin
      pc_d = JADDR;
    end else if (PCE) begin
      pc_d = pc_q + AW'(1);
    end

    fcnt_d = fcnt_q;
    if (T1 && (fcnt_q != {CW{1'b1}})) begin
      fcnt_d = fcnt_q + CW'(1);
    end

    err_d = err_q | multi_state;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      instr_q <= '0;
      pc_q    <= '0;
      fcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      fcnt_q  <= fcnt_d;
      err_q   <= err_d;
    end
  end

  assign I    = instr_q;
  assign PC   = pc_q;
  assign FCNT = fcnt_q;
  assign ERR  = err_q;

endmodule

// File: tb/tb_mrmini_fetch_server.sv
module tb_mrmini_fetch_server;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          T1 = 1'b0, T2 = 1'b0, T3 = 1'b0, T4 = 1'b0;
  logic          PCE = 1'b0, JMP = 1'b0;
  logic [AW-1:0] JADDR = '0;
  logic          LD_EN = 1'b0;
  logic [AW-1:0] LD_ADDR = '0;
  logic [DW-1:0] LD_DATA = '0;
  logic [DW-1:0] I;
  logic [AW-1:0] PC;
  logic [CW-1:0] FCNT;
  logic          ERR;

  int n_cmp = 0;
  int n_bad = 0;

  mrmini_fetch_server #(.AW(AW), .DW(DW), .CW(CW)) dut (
    .CLK(CLK), .RST(RST),
    .T1(T1), .T2(T2), .T3(T3), .T4(T4),
    .PCE(PCE), .JMP(JMP), .JADDR(JADDR),
    .LD_EN(LD_EN), .LD_ADDR(LD_ADDR), .LD_DATA(LD_DATA),
    .I(I), .PC(PC), .FCNT(FCNT), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    T1 = 0; T2 = 0; T3 = 0; T4 = 0; PCE = 0; JMP = 0; LD_EN = 0;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    LD_EN = 1; LD_ADDR = a; LD_DATA = d;
    tick();
    LD_EN = 0;
  endtask

  task automatic pulse_reset();
    RST = 1; #2; RST = 0;
    tick();
  endtask

  task automatic test_reset();
    idle();
    RST = 1;
    tick();
    n_cmp++; if (I !== 16'h0000) begin n_bad++; $display("FAIL reset_i got %h want 0000", I); end
    n_cmp++; if (PC !== 4'h0) begin n_bad++; $display("FAIL reset_pc got %h want 0", PC); end
    n_cmp++; if (FCNT !== 16'h0000) begin n_bad++; $display("FAIL reset_fcnt got %h want 0000", FCNT); end
    n_cmp++; if (ERR !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", ERR); end
    RST = 0;
    tick();
  endtask

  task automatic test_fetch();
    load(0, 16'h0001); load(1, 16'h0080); load(2, 16'h0003); load(3, 16'h00FF);
    pulse_reset();
    T1 = 1; tick();
    n_cmp++; if (I !== 16'h0001) begin n_bad++; $display("FAIL fetch0_i got %h want 0001", I); end
    n_cmp++; if (FCNT !== 16'd1) begin n_bad++; $display("FAIL fetch0_fcnt got %h want 0001", FCNT); end
    T1 = 0; T2 = 1; PCE = 1; tick();
    n_cmp++; if (PC !== 4'h1) begin n_bad++; $display("FAIL fetch_pce1 got %h want 1", PC); end
    n_cmp++; if (I !== 16'h0001) begin n_bad++; $display("FAIL fetch_hold got %h want 0001", I); end
    T2 = 0; PCE = 0; T1 = 1; tick();
    n_cmp++; if (I !== 16'h0080) begin n_bad++; $display("FAIL fetch1_i got %h want 0080", I); end
    n_cmp++; if (FCNT !== 16'd2) begin n_bad++; $display("FAIL fetch1_fcnt got %h want 0002", FCNT); end
    T1 = 0; PCE = 1; tick();
    n_cmp++; if (PC !== 4'h2) begin n_bad++; $display("FAIL fetch_pce2 got %h want 2", PC); end
    idle();
  endtask

  task automatic test_wrap();
    JMP = 1; JADDR = 4'hF; tick(); JMP = 0;
    n_cmp++; if (PC !== 4'hF) begin n_bad++; $display("FAIL wrap_jmp got %h want f", PC); end
    PCE = 1; tick(); PCE = 0;
    n_cmp++; if (PC !== 4'h0) begin n_bad++; $display("FAIL wrap_pc got %h want 0", PC); end
    T1 = 1; tick(); T1 = 0;
    n_cmp++; if (I !== 16'h0001) begin n_bad++; $display("FAIL wrap_fetch got %h want 0001", I); end
  endtask

  task automatic test_jmp_pce();
    JMP = 1; JADDR = 4'h2; tick();
    JADDR = 4'h5; PCE = 1; T1 = 1; tick();
    idle();
    n_cmp++; if (PC !== 4'h5) begin n_bad++; $display("FAIL jmp_pce_pc got %h want 5", PC); end
    n_cmp++; if (I !== 16'h0003) begin n_bad++; $display("FAIL jmp_old_pc_fetch got %h want 0003", I); end
  endtask

  task automatic test_rbw();
    load(6, 16'h1234);
    JMP = 1; JADDR = 4'h6; tick(); JMP = 0;
    LD_EN = 1; LD_ADDR = 4'h6; LD_DATA = 16'hABCD; T1 = 1; tick();
    LD_EN = 0;
    n_cmp++; if (I !== 16'h1234) begin n_bad++; $display("FAIL rbw_old got %h want 1234", I); end
    tick(); T1 = 0;
    n_cmp++; if (I !== 16'hABCD) begin n_bad++; $display("FAIL rbw_new got %h want abcd", I); end
  endtask

  task automatic test_err();
    n_cmp++; if (ERR !== 1'b0) begin n_bad++; $display("FAIL err_clean got %b want 0", ERR); end
    T1 = 1; T3 = 1; tick(); T1 = 0; T3 = 0;
    n_cmp++; if (ERR !== 1'b1) begin n_bad++; $display("FAIL err_set got %b want 1", ERR); end
    // Fetch still happens: PC=6 holds ABCD.
    n_cmp++; if (I !== 16'hABCD) begin n_bad++; $display("FAIL err_fetch got %h want abcd", I); end
    T1 = 1; tick(); T1 = 0; T2 = 1; tick(); T2 = 0; tick();
    n_cmp++; if (ERR !== 1'b1) begin n_bad++; $display("FAIL err_sticky got %b want 1", ERR); end
    pulse_reset();
    n_cmp++; if (ERR !== 1'b0) begin n_bad++; $display("FAIL err_clear got %b want 0", ERR); end
  endtask

  task automatic test_async_reset();
    T1 = 1; tick(); T1 = 0; PCE = 1; tick(); PCE = 0;
    n_cmp++; if (I !== 16'h0001 || PC !== 4'h1) begin
      n_bad++; $display("FAIL ar_pre got I=%h PC=%h want 0001/1", I, PC);
    end
    #2; RST = 1; #1;
    n_cmp++; if (I !== 16'h0000) begin n_bad++; $display("FAIL ar_i got %h want 0000", I); end
    n_cmp++; if (PC !== 4'h0) begin n_bad++; $display("FAIL ar_pc got %h want 0", PC); end
    n_cmp++; if (FCNT !== 16'h0000) begin n_bad++; $display("FAIL ar_fcnt got %h want 0000", FCNT); end
    RST = 0;
    tick();
    T1 = 1; tick(); T1 = 0;
    n_cmp++; if (I !== 16'h0001) begin n_bad++; $display("FAIL ar_first_fetch got %h want 0001", I); end
  endtask

  task automatic test_fcnt_sat();
    pulse_reset();
    T1 = 1;
    repeat (65534) @(posedge CLK);
    #1;
    n_cmp++; if (FCNT !== 16'hFFFE) begin n_bad++; $display("FAIL fcnt_near got %h want fffe", FCNT); end
    repeat (4466) @(posedge CLK);
    #1;
    T1 = 0;
    n_cmp++; if (FCNT !== 16'hFFFF) begin n_bad++; $display("FAIL fcnt_sat got %h want ffff", FCNT); end
    n_cmp++; if (ERR !== 1'b0) begin n_bad++; $display("FAIL fcnt_err got %b want 0", ERR); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_wrap();
    test_jmp_pce();
    test_rbw();
    test_err();
    test_async_reset();
    test_fcnt_sat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
